// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Front-end stage for the board push-buttons. Every channel is handled on its
// own: the raw input is polarity-normalised, passed through a 2-flop
// synchroniser, debounced, and turned into clean one-cycle press / release
// pulses plus an auto-repeat strobe so a held button keeps stepping a counter.
//
// Ports
//   i_clk      system clock
//   i_rst      asynchronous, active-high reset
//   i_btn      raw, asynchronous, bouncing button inputs (N_BTN bits)
//   o_level    debounced pressed level (1 = pressed)
//   o_press    one-cycle pulse in the first cycle of a new pressed level
//   o_release  one-cycle pulse in the first cycle of a new released level
//   o_repeat   one-cycle auto-repeat pulse while the button is held
//   o_step     o_press OR o_repeat; the single strobe for downstream counters
//
// Handshake: there is none. All outputs are registered, level-style or
// single-cycle strobes, and the consumer samples them every clock.
//
// Debug: each channel's repeat FSM state is held in ch[g].state_q
// (rep_state_e) so checkers can bind to it hierarchically.
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat,
    output logic [N_BTN-1:0] o_step
);

    // Counter widths; a 1-cycle setting still gets a 1-bit counter.
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W    = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LOAD = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_LOAD   = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    for (genvar g = 0; g < N_BTN; g++) begin : ch
        logic            raw_norm;
        logic            s1_q;
        logic            s2_q;
        logic            stable_q,  stable_d;
        logic [DB_W-1:0] db_cnt_q,  db_cnt_d;
        rep_state_e      state_q,   state_d;
        logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic            press_q,   press_d;
        logic            release_q, release_d;
        logic            repeat_q,  repeat_d;
        logic            step_q,    step_d;

        // Inversion happens before the synchroniser so both flops always
        // carry "1 = pressed".
        assign raw_norm = (BTN_ACTIVE_LOW != 0) ? ~i_btn[g] : i_btn[g];

        // Debounce: the synchronised level has to disagree with the stable
        // level on DEBOUNCE_CYCLES consecutive edges; a single agreeing
        // cycle restarts the count. Press/release are decided at the same
        // edge the stable level flips.
        always_comb begin
            stable_d  = stable_q;
            db_cnt_d  = db_cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s2_q == stable_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                stable_d  = ~stable_q;
                db_cnt_d  = '0;
                press_d   = ~stable_q;
                release_d = stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Auto-repeat: counts down from the press; an expiry on the same
        // edge as a release is dropped because the release takes priority.
        always_comb begin
            state_d   = state_q;
            rep_cnt_d = rep_cnt_q;
            repeat_d  = 1'b0;
            if (release_d) begin
                state_d   = ST_IDLE;
                rep_cnt_d = '0;
            end else if (press_d) begin
                state_d   = ST_DELAY;
                rep_cnt_d = DELAY_LOAD;
            end else begin
                case (state_q)
                    ST_DELAY, ST_REPEAT: begin
                        if (rep_cnt_q == '0) begin
                            repeat_d  = 1'b1;
                            rep_cnt_d = PER_LOAD;
                            state_d   = ST_REPEAT;
                        end else begin
                            rep_cnt_d = rep_cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end
                endcase
            end
            step_d = press_d | repeat_d;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                stable_q  <= 1'b0;
                db_cnt_q  <= '0;
                state_q   <= ST_IDLE;
                rep_cnt_q <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                step_q    <= 1'b0;
            end else begin
                s1_q      <= raw_norm;
                s2_q      <= s1_q;
                stable_q  <= stable_d;
                db_cnt_q  <= db_cnt_d;
                state_q   <= state_d;
                rep_cnt_q <= rep_cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
                step_q    <= step_d;
            end
        end

        assign o_level[g]   = stable_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_repeat[g]  = repeat_q;
        assign o_step[g]    = step_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Drives two copies of btn_conditioner (active-high and active-low raw
// polarity) with identical logical stimulus and checks both against one
// reference model. The model works from the observable rules: the value seen
// by the debouncer is the raw value captured two edges earlier; the level
// flips when the last DEBOUNCE_CYCLES seen values all differ from it; repeats
// fall at press_edge + REPEAT_DELAY + n*REPEAT_PERIOD while held.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;
    localparam int NB = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NB-1:0] btn, btn_al;
    logic [NB-1:0] lvl, prs, rel, rpt, stp;
    logic [NB-1:0] lvl_al, prs_al, rel_al, rpt_al, stp_al;

    btn_conditioner #(
        .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .BTN_ACTIVE_LOW(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lvl), .o_press(prs), .o_release(rel),
        .o_repeat(rpt), .o_step(stp)
    );

    btn_conditioner #(
        .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .BTN_ACTIVE_LOW(1)
    ) dut_al (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_al),
        .o_level(lvl_al), .o_press(prs_al), .o_release(rel_al),
        .o_repeat(rpt_al), .o_step(stp_al)
    );

    // ---------------- scoreboard / model state ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // Expected word per edge: {step, repeat, release, press, level}
    logic [9:0] exp_q[$];
    logic [1:0] raw_hist[$];
    logic [1:0] seen_hist[$];
    logic [1:0] m_stable;
    logic [1:0] m_held;
    int         m_press_t[NB];
    int         t;

    logic [1:0] cur_raw;
    int         run_left[NB];
    logic [1:0] acc_press, acc_release, acc_any;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        raw_hist.delete();
        seen_hist.delete();
        exp_q.delete();
        m_stable = 2'b00;
        m_held   = 2'b00;
        for (int c = 0; c < NB; c++) m_press_t[c] = 0;
        t = 0;
    endfunction

    function automatic void model_edge(input logic [1:0] r);
        logic [1:0] seen, rise, fall, rep;
        bit         all_diff;
        raw_hist.push_back(r);
        if (raw_hist.size() > 8) void'(raw_hist.pop_front());
        seen = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3] : 2'b00;
        seen_hist.push_back(seen);
        if (seen_hist.size() > 8) void'(seen_hist.pop_front());
        rise = 2'b00;
        fall = 2'b00;
        rep  = 2'b00;
        for (int c = 0; c < NB; c++) begin
            all_diff = 1'b0;
            if (seen_hist.size() >= DB) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (seen_hist[seen_hist.size() - j][c] == m_stable[c]) all_diff = 1'b0;
            end
            if (all_diff) begin
                rise[c]     = ~m_stable[c];
                fall[c]     = m_stable[c];
                m_stable[c] = ~m_stable[c];
            end
            if (rise[c]) begin
                m_held[c]    = 1'b1;
                m_press_t[c] = t;
            end
            if (fall[c]) m_held[c] = 1'b0;
            if (m_held[c] && !rise[c] && (t - m_press_t[c] >= RD)
                && (((t - m_press_t[c] - RD) % RP) == 0))
                rep[c] = 1'b1;
        end
        exp_q.push_back({rise | rep, rep, fall, rise, m_stable});
        t++;
    endfunction

    task automatic check_outputs();
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            chk_cnt++;
            fail_cnt++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = exp_q.pop_front();
        check("level",      lvl,    e[1:0]);
        check("press",      prs,    e[3:2]);
        check("release",    rel,    e[5:4]);
        check("repeat",     rpt,    e[7:6]);
        check("step",       stp,    e[9:8]);
        check("level_al",   lvl_al, e[1:0]);
        check("press_al",   prs_al, e[3:2]);
        check("release_al", rel_al, e[5:4]);
        check("repeat_al",  rpt_al, e[7:6]);
        check("step_al",    stp_al, e[9:8]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic [1:0] r);
        btn    = r;
        btn_al = ~r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},  lvl | lvl_al, 2'b00);
        check({tag, "_press"},  prs | prs_al, 2'b00);
        check({tag, "_rel"},    rel | rel_al, 2'b00);
        check({tag, "_repeat"}, rpt | rpt_al, 2'b00);
        check({tag, "_step"},   stp | stp_al, 2'b00);
    endtask

    // Assert reset mid-cycle (raw inputs untouched), verify the outputs
    // drop at once, then release on a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick(2'b00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        btn    = 2'b00;
        btn_al = 2'b11;
        model_reset();
        #1 check_all_zero("reset_init");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("after_reset");

        // 1. clean press on btn0, 31 captured samples of 1 (edges 0..30)
        for (int i = 1; i <= 31; i++) begin
            tick(2'b01);
            if (i == 5)  check("clean_level_pre",  lvl, 2'b00);
            if (i == 6)  check("clean_press",      prs, 2'b01);
            if (i == 6)  check("clean_step",       stp, 2'b01);
            if (i == 7)  check("press_one_cycle",  prs, 2'b00);
            if (i == 16) check("first_repeat",     rpt, 2'b01);
            if (i == 19) check("second_repeat",    rpt, 2'b01);
            if (i == 31) check("last_repeat",      rpt, 2'b01);
        end
        settle(12);

        // 2. bounce 1,0,1,0,1 then hold
        acc_press   = 2'b00;
        acc_release = 2'b00;
        for (int i = 0; i < 16; i++) begin
            tick((i < 5) ? ((i % 2 == 0) ? 2'b01 : 2'b00) : 2'b01);
            if (prs[0] && acc_press != 2'b11)   acc_press++;
            if (rel[0] && acc_release != 2'b11) acc_release++;
        end
        check("bounce_press_count",   acc_press,   2'b01);
        check("bounce_release_count", acc_release, 2'b00);
        settle(12);

        // 3. glitch: 3 high samples then low
        acc_any = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick((i < 3) ? 2'b01 : 2'b00);
            acc_any = acc_any | lvl | prs | rel | stp;
        end
        check("glitch_quiet", acc_any, 2'b00);

        // 4. release landing on a repeat expiry (press P=k+5, fall at P+13)
        for (int i = 0; i < 13; i++) tick(2'b01);
        for (int i = 0; i < 6; i++) tick(2'b00);
        check("release_wins_rel", rel, 2'b01);
        check("release_wins_rpt", rpt, 2'b00);
        check("release_wins_stp", stp, 2'b00);
        settle(10);

        // 5. simultaneous press, held into REPEAT
        for (int i = 1; i <= 20; i++) begin
            tick(2'b11);
            if (i == 6)  check("simul_press",  prs, 2'b11);
            if (i == 16) check("simul_repeat", rpt, 2'b11);
            if (i == 19) check("simul_repeat2", rpt, 2'b11);
        end

        // 6. reset mid-hold, button still held afterwards
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            tick(2'b11);
            if (i == 5) check("rst_press_early", prs, 2'b00);
            if (i == 6) check("rst_press_refire", prs, 2'b11);
        end
        settle(12);

        // randomized independent runs per channel, one reset in the middle
        run_left[0] = 0;
        run_left[1] = 0;
        cur_raw     = 2'b00;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (run_left[c] == 0) begin
                    cur_raw[c]  = 1'($urandom_range(0, 1));
                    run_left[c] = $urandom_range(1, 16);
                end
            end
            tick(cur_raw);
            run_left[0]--;
            run_left[1]--;
            if (n == 150) apply_reset();
        end
        settle(12);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Front-end input stage for the board push-buttons. It feeds the 7-segment counter and other button-driven logic.
Each raw button input is synchronised, debounced and converted into clean single-cycle press and release pulses. It also produces an auto-repeat step pulse, so a held button keeps stepping a downstream counter.
All outputs are registered and all buttons are handled independently.

Parameters:
N_BTN, 2, number of independent button channels
DEBOUNCE_CYCLES, 240000, consecutive cycles (20 ms at 12 MHz) a synchronised level must differ from the stable level before it is accepted; must be >= 1
REPEAT_DELAY, 6000000, cycles from accepted press to first auto-repeat pulse; must be >= 1
REPEAT_PERIOD, 1200000, cycles between later auto-repeat pulses; must be >= 1
BTN_ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed; inversion is applied before synchronisation

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_btn  input  N_BTN  raw, asynchronous, bouncing button inputs
o_level  output  N_BTN  debounced pressed level (1 = pressed)
o_press  output  N_BTN  one-cycle pulse when o_level rises
o_release  output  N_BTN  one-cycle pulse when o_level falls
o_repeat  output  N_BTN  one-cycle auto-repeat pulse while held
o_step  output  N_BTN  o_press OR o_repeat (registered); the single increment/decrement strobe for downstream counters

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset: all sync flops, stable levels, counters and outputs clear to 0. Per-channel FSM goes to IDLE. No pulse is emitted on reset assertion or deassertion.
- Synchronisation: per channel, polarity-normalise, then pass through a 2-flop synchroniser (s1, s2). Nothing downstream sees s1.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES):
  - If s2 == stable: counter clears.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable toggles and counter clears.
  - Otherwise: counter increments.
  - Any single cycle of agreement restarts the count. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes o_level.
- Latency: let edge k be the edge where s1 first captures a new raw value that then stays constant. o_level updates at edge k+1+DEBOUNCE_CYCLES.
- Pulses: o_press and o_release are set at the same edge stable changes and cleared at the next edge, so each is exactly one cycle wide and coincides with the first cycle of the new o_level.
- Auto-repeat FSM, per channel:
  - IDLE -> DELAY on stable rise; load the repeat counter with REPEAT_DELAY-1.
  - DELAY: decrement each cycle. At 0, pulse o_repeat, reload with REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: decrement each cycle. At 0, pulse o_repeat and reload with REPEAT_PERIOD-1.
  - From any state, stable fall -> IDLE at that edge.
- Repeat timing: with the press pulse at edge P, repeats occur at edges P+REPEAT_DELAY, then P+REPEAT_DELAY+n*REPEAT_PERIOD, for n >= 1, while held.
- Release vs repeat: if the stable fall and a repeat expiry land on the same edge, the release wins. o_release pulses and o_repeat does not.
- o_step: asserted in exactly the cycles where o_press or o_repeat is high. It is never high in the same cycle as o_release.
- Channel independence: channels share no state. Simultaneous presses on several channels each produce their own pulses in the same cycle. Arbitration between buttons (for example up vs down) belongs to the consumer.
- Reset mid-operation: counters and FSMs abort and outputs drop to 0 immediately (asynchronously). A button still held after reset release is treated as a new press and yields o_press DEBOUNCE_CYCLES+2 edges after reset deassertion.
- Repeat counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).

Test Plan:
Bench parameters for all scenarios: N_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=0.
1. Clean press on btn0: raw 0->1, sampled at edge 0, held 30 cycles -> o_level[0] rises at edge 5; o_press[0] and o_step[0] high for exactly one cycle after edge 5; o_repeat[0] pulses at edges 15, 18, 21, 24, 27, 30; btn1 outputs stay 0.
2. Bounce: raw toggles 1,0,1,0,1 on successive edges, then holds 1 -> no output change until 4 consecutive agreeing synchronised cycles; exactly one o_press and no o_release.
3. Glitch: raw high for 3 cycles, then low -> o_level, o_press, o_release and o_step all stay 0.
4. Release: press held until o_level goes high, then raw low sampled at edge R -> o_level falls at edge R+5 with a one-cycle o_release. Timing the release so the fall lands on a repeat-expiry edge gives o_release with no o_repeat.
5. Simultaneous: btn0 and btn1 rise at the same edge -> o_press = 2'b11 for one cycle, then identical repeat trains on both channels.
6. Reset mid-hold: assert i_rst during REPEAT with raw held, deassert -> outputs 0 immediately; o_press re-fires 6 edges after deassert; BTN_ACTIVE_LOW=1 variant gives the same results with inverted raw stimulus.
